// File: rtl/vram_fill_if.sv
// Write/command bundle between the CPU side, the fill engine and the scan-out
// block's write port; slave is the fill engine, master is whoever drives it.
interface vram_fill_if;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        fill_start;
  logic [8:0]  fill_x;
  logic [7:0]  fill_y;
  logic [8:0]  fill_w;
  logic [7:0]  fill_h;
  logic [7:0]  fill_color;
  logic        busy;
  logic        done;
  logic        vram_wr;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;

  modport slave (
    input  cpu_wr, cpu_addr, cpu_data,
    input  fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
    output busy, done, vram_wr, vram_addr, vram_data
  );

  modport master (
    output cpu_wr, cpu_addr, cpu_data,
    output fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
    input  busy, done, vram_wr, vram_addr, vram_data
  );
endinterface

// File: rtl/vram_fill.sv
// Clipped rectangle fill engine merged with CPU byte writes into one registered
// VRAM write stream; CPU writes always win and stall the fill for that cycle.
module vram_fill #(
  parameter int VGA_WIDTH  = 320,
  parameter int VGA_HEIGHT = 200
) (
  input logic        cpu_clk,
  input logic        reset,
  vram_fill_if.slave bus
);
  localparam logic [9:0]  W10 = 10'(VGA_WIDTH);
  localparam logic [9:0]  H10 = 10'(VGA_HEIGHT);
  localparam logic [15:0] W16 = 16'(VGA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  state_t state, state_nxt;

  logic [8:0]  lat_x, lat_w;
  logic [7:0]  lat_y, lat_h, lat_color;
  logic [9:0]  x_end, y_end;
  logic [8:0]  cur_x;
  logic [7:0]  cur_y;
  logic [15:0] row_base;

  logic [9:0]  x_sum, y_sum, x_inc, y_inc;
  logic        empty, row_last, last_px, stall, accept, advance;
  logic        busy_nxt, done_nxt;

  // 10-bit sums so x+w / y+h cannot wrap before clipping
  assign x_sum    = {1'b0, lat_x} + {1'b0, lat_w};
  assign y_sum    = {2'b0, lat_y} + {2'b0, lat_h};
  assign empty    = ({1'b0, lat_x} >= W10) || ({2'b0, lat_y} >= H10) ||
                    (lat_w == '0) || (lat_h == '0);
  assign x_inc    = {1'b0, cur_x} + 10'd1;
  assign y_inc    = {2'b0, cur_y} + 10'd1;
  assign row_last = (x_inc == x_end);
  assign last_px  = row_last && (y_inc == y_end);
  assign stall    = bus.cpu_wr;
  assign accept   = (state == IDLE) && bus.fill_start;
  assign advance  = (state == FILL) && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fill_start) state_nxt = SETUP;
      SETUP:   state_nxt = empty ? DONE : FILL;
      FILL:    if (advance && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == DONE);
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Output stage: CPU write first, otherwise the current fill pixel
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.vram_wr   <= 1'b0;
      bus.vram_addr <= '0;
      bus.vram_data <= '0;
    end else begin
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      if (bus.cpu_wr) begin
        bus.vram_wr   <= 1'b1;
        bus.vram_addr <= bus.cpu_addr;
        bus.vram_data <= bus.cpu_data;
      end else if (state == FILL) begin
        bus.vram_wr   <= 1'b1;
        bus.vram_addr <= row_base + {7'b0, cur_x};
        bus.vram_data <= lat_color;
      end else begin
        bus.vram_wr   <= 1'b0;
      end
    end
  end

  // Datapath: command latch, clip/setup, incremental walk (y*320 as shifts)
  always_ff @(posedge cpu_clk) begin
    if (accept) begin
      lat_x     <= bus.fill_x;
      lat_y     <= bus.fill_y;
      lat_w     <= bus.fill_w;
      lat_h     <= bus.fill_h;
      lat_color <= bus.fill_color;
    end
    if (state == SETUP) begin
      x_end    <= (x_sum > W10) ? W10 : x_sum;
      y_end    <= (y_sum > H10) ? H10 : y_sum;
      cur_x    <= lat_x;
      cur_y    <= lat_y;
      row_base <= ({8'b0, lat_y} << 8) + ({8'b0, lat_y} << 6);
    end else if (advance) begin
      if (row_last) begin
        cur_x    <= lat_x;
        cur_y    <= cur_y + 8'd1;
        row_base <= row_base + W16;
      end else begin
        cur_x    <= cur_x + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_vram_fill.sv
// Directed bench for vram_fill: CPU pass-through, fills, clipping, CPU
// collision, start-while-busy and reset mid-fill.
module tb_vram_fill;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_fill_if bus();

  vram_fill #(.VGA_WIDTH(320), .VGA_HEIGHT(200)) dut (
    .cpu_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_addr [0:7];
  int exp_n;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_wr"},   32'(bus.vram_wr), 0);
    chk({tag, "_addr"}, 32'(bus.vram_addr), 0);
    chk({tag, "_data"}, 32'(bus.vram_data), 0);
  endtask

  task automatic start(input logic [8:0] x, input logic [7:0] y,
                       input logic [8:0] w, input logic [7:0] h, input logic [7:0] c);
    bus.fill_x = x; bus.fill_y = y; bus.fill_w = w; bus.fill_h = h;
    bus.fill_color = c;
    bus.fill_start = 1'b1;
    step;
    bus.fill_start = 1'b0;
  endtask

  // Start a fill and expect exp_addr[0..exp_n-1] from N+2, then done.
  task automatic run_fill(input string tag, input logic [8:0] x, input logic [7:0] y,
                          input logic [8:0] w, input logic [7:0] h, input logic [7:0] c);
    start(x, y, w, h, c);
    chk({tag, "_busy_n"}, 32'(bus.busy), 1);
    chk({tag, "_wr_n"}, 32'(bus.vram_wr), 0);
    step;
    chk({tag, "_busy_n1"}, 32'(bus.busy), 1);
    chk({tag, "_wr_n1"}, 32'(bus.vram_wr), 0);
    for (int i = 0; i < exp_n; i++) begin
      step;
      chk($sformatf("%s_wr%0d", tag, i), 32'(bus.vram_wr), 1);
      chk($sformatf("%s_addr%0d", tag, i), 32'(bus.vram_addr), 32'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(bus.vram_data), 32'(c));
      chk($sformatf("%s_nodone%0d", tag, i), 32'(bus.done), 0);
    end
    step;
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_busy_off"}, 32'(bus.busy), 0);
    chk({tag, "_wr_off"}, 32'(bus.vram_wr), 0);
    step;
    chk({tag, "_done_1cyc"}, 32'(bus.done), 0);
  endtask

  task automatic set_small;
    exp_addr[0] = 16'd1610; exp_addr[1] = 16'd1611; exp_addr[2] = 16'd1612;
    exp_addr[3] = 16'd1930; exp_addr[4] = 16'd1931; exp_addr[5] = 16'd1932;
    exp_n = 6;
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.fill_start = 1'b0; bus.fill_x = '0; bus.fill_y = '0;
    bus.fill_w = '0; bus.fill_h = '0; bus.fill_color = '0;
    step; step;
    chk_zero("reset");
    reset = 1'b0;
    step;
    chk("idle_busy", 32'(bus.busy), 0);

    // CPU pass-through while idle
    bus.cpu_wr = 1'b1; bus.cpu_addr = 16'hBEEF; bus.cpu_data = 8'hA5;
    step;
    bus.cpu_wr = 1'b0;
    chk("cpu_wr", 32'(bus.vram_wr), 1);
    chk("cpu_addr", 32'(bus.vram_addr), 32'h0000BEEF);
    chk("cpu_data", 32'(bus.vram_data), 32'h000000A5);
    step;
    chk("cpu_wr_off", 32'(bus.vram_wr), 0);
    chk("cpu_addr_hold", 32'(bus.vram_addr), 32'h0000BEEF);

    // Full clear: 64000 consecutive writes
    start(9'd0, 8'd0, 9'd320, 8'd200, 8'h00);
    chk("clear_busy", 32'(bus.busy), 1);
    step;
    chk("clear_setup_wr", 32'(bus.vram_wr), 0);
    bad = 0;
    for (int i = 0; i < 64000; i++) begin
      step;
      if (!(bus.vram_wr === 1'b1 && bus.vram_addr === 16'(i) && bus.vram_data === 8'h00 &&
            bus.done === 1'b0 && bus.busy === 1'b1)) bad++;
    end
    chk("clear_seq_errors", 32'(bad), 0);
    step;
    chk("clear_done", 32'(bus.done), 1);
    chk("clear_busy_off", 32'(bus.busy), 0);
    chk("clear_wr_off", 32'(bus.vram_wr), 0);
    chk("clear_addr_hold", 32'(bus.vram_addr), 32'd63999);
    step;
    chk("clear_done_1cyc", 32'(bus.done), 0);

    // Small rectangle
    set_small;
    run_fill("small", 9'd10, 8'd5, 9'd3, 8'd2, 8'hE0);

    // Clipped at bottom-right corner
    exp_addr[0] = 16'd63998; exp_addr[1] = 16'd63999; exp_n = 2;
    run_fill("clip", 9'd318, 8'd199, 9'd10, 8'd10, 8'h1C);

    // Empty rectangles
    exp_n = 0;
    run_fill("empty_x", 9'd320, 8'd0, 9'd5, 8'd5, 8'h55);
    run_fill("empty_y", 9'd0, 8'd200, 9'd4, 8'd4, 8'h55);
    run_fill("empty_h", 9'd5, 8'd5, 9'd5, 8'd0, 8'h55);

    // CPU write collides with the 3rd fill pixel
    set_small;
    start(9'd10, 8'd5, 9'd3, 8'd2, 8'hE0);
    step;
    step;
    chk("coll_a0", 32'(bus.vram_addr), 32'd1610);
    step;
    chk("coll_a1", 32'(bus.vram_addr), 32'd1611);
    bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_data = 8'h55;
    step;
    bus.cpu_wr = 1'b0;
    chk("coll_cpu_wr", 32'(bus.vram_wr), 1);
    chk("coll_cpu_addr", 32'(bus.vram_addr), 32'h00001234);
    chk("coll_cpu_data", 32'(bus.vram_data), 32'h00000055);
    for (int i = 2; i < 6; i++) begin
      step;
      chk($sformatf("coll_wr%0d", i), 32'(bus.vram_wr), 1);
      chk($sformatf("coll_addr%0d", i), 32'(bus.vram_addr), 32'(exp_addr[i]));
      chk($sformatf("coll_data%0d", i), 32'(bus.vram_data), 32'h000000E0);
      chk($sformatf("coll_nodone%0d", i), 32'(bus.done), 0);
    end
    step;
    chk("coll_done", 32'(bus.done), 1);
    chk("coll_busy_off", 32'(bus.busy), 0);

    // Second start while busy is ignored
    start(9'd10, 8'd5, 9'd3, 8'd2, 8'hE0);
    step;
    step;
    chk("sb_a0", 32'(bus.vram_addr), 32'd1610);
    bus.fill_x = 9'd0; bus.fill_y = 8'd0; bus.fill_w = 9'd2; bus.fill_h = 8'd2;
    bus.fill_color = 8'hFF; bus.fill_start = 1'b1;
    step;
    bus.fill_start = 1'b0;
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("sb_addr%0d", i), 32'(bus.vram_addr), 32'(exp_addr[i]));
      chk($sformatf("sb_data%0d", i), 32'(bus.vram_data), 32'h000000E0);
      if (i < 5) step;
    end
    step;
    chk("sb_done", 32'(bus.done), 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (bus.vram_wr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("sb_quiet_after", 32'(bad), 0);

    // Reset in the middle of a full clear
    start(9'd0, 8'd0, 9'd320, 8'd200, 8'h00);
    step;
    for (int i = 0; i < 100; i++) step;
    chk("rst_mid_addr", 32'(bus.vram_addr), 32'd99);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk_zero("rst_mid");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (bus.vram_wr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("rst_mid_quiet", 32'(bad), 0);
    set_small;
    run_fill("after_rst", 9'd10, 8'd5, 9'd3, 8'd2, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
